mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access controller of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and turns load/store controls into a req/ack transaction on the data-memory bus. It handles byte/halfword lane selection and load sign/zero extension, and produces the write-back result. It drives the pipeline-wide hold request (`stall_req`) until the access completes.

## Interface
- `DATA_W`, 32, data and address width
- `OPC_W`, 6, opcode width (MIPS primary opcode)
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `addr_MEM`  in  DATA_W  effective address (ALU result from EX/MEM)
- `rdata_2_MEM`  in  DATA_W  store data
- `ReadMem_MEM`, `WriteMem_MEM`, `MemOrAlu_MEM`, `WriteReg_MEM`  in  1  control bits from EX/MEM
- `opcode_MEM`  in  OPC_W  selects access size/extension
- `target_MEM`  in  5  destination register
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  DATA_W  word address, `{addr_MEM[DATA_W-1:2],2'b00}`
- `mem_be`  out  4  byte enables (bit i = byte lane i, little-endian)
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_ack`  in  1  transfer complete; read data valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `stall_req`  out  1  hold request to PC/IF_ID/ID_EX/EX_MEM
- `result_WB`  out  DATA_W  `MemOrAlu_MEM ? load_data : addr_MEM`
- `target_WB`  out  5  = `target_MEM`
- `WriteReg_WB`  out  1  = `WriteReg_MEM & ~addr_err`
- `addr_err`  out  1  misaligned-access flag

## Operation
- mem_op = `ReadMem_MEM | WriteMem_MEM`; both high: treated as read, write ignored.
- FSM states IDLE, REQ, DONE.
  - IDLE: mem_op & ~addr_err → REQ; else stay.
  - REQ: `mem_req`=1; on `mem_ack` capture `mem_rdata` into rdata_q → DONE.
  - DONE: → IDLE unconditionally.
- `stall_req` = (IDLE & mem_op & ~addr_err) | REQ; 0 in DONE.
- Bus outputs in REQ are combinational from EX/MEM inputs; these are frozen by the hold, so they stay stable until ack. `mem_req`/`mem_we`/`mem_be` are 0 outside REQ.
- Stores: SB(0x28) `mem_be`=1<<addr[1:0], wdata={4{b}}; SH(0x29) `mem_be`=addr[1]?1100:0011, wdata={2{h}}; SW(0x2B) 1111.
- Reads always set `mem_be`=1111.
- Loads from rdata_q: LB(0x20)/LBU(0x24) take byte lane addr[1:0], sign/zero-extended; LH(0x21)/LHU(0x25) take lane addr[1], sign/zero-extended; LW(0x23) full word. Unknown opcodes with ReadMem are treated as LW.
- load_data is valid only in DONE; `result_WB` is consumed by MEM/WB at the DONE edge.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, rdata_q 0, `mem_req` 0, `mem_we` 0, `mem_be` 0, `stall_req` 0, `addr_err` 0.
- Latency with a zero-wait bus (ack in first REQ cycle):
  - cycle 0: op enters, IDLE, stall=1
  - cycle 1: REQ, req=1, ack=1
  - cycle 2: DONE, stall=0; pipeline advances at end of cycle 2
- Each wait cycle of ack adds one cycle.
- Non-memory instruction: zero added cycles, `stall_req`=0, result = `addr_MEM`.
- Back-to-back memory ops: the second op enters in the cycle after DONE, in IDLE.
- Reset asserted in REQ: `mem_req` drops immediately (async). The bus must tolerate an abandoned request. The op is not retried.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: in IDLE, `addr_err`=1 combinationally for mem_op with LH/LHU/SH & addr[0], or LW/SW & addr[1:0]≠0.
  - No bus request; no stall.
  - `WriteReg_WB` forced 0; `result_WB` = 0 when `MemOrAlu_MEM`.
- Undefined: `addr_err` tied 0; low address bits that conflict with the size are ignored (SH/LH use addr[1]; SW/LW use word address).

## Test plan
- SW addr 0x1000, data 0xDEADBEEF, ack immediate → req in cycle 1 only, be=1111, we=1, stall high cycles 0–1, low cycle 2.
- LB addr 0x1003, mem_rdata 0x80000000 → result_WB 0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x2002 data 0x0000ABCD → be=1100, wdata 0xABCDABCD; ack delayed 3 cycles → req stable 3+1 cycles, stall released only in DONE.
- LW then LH back-to-back, both zero-wait → 6 total cycles; second result correct lane.
- With `MEM_ALIGN_CHECK_EN`: LW addr 0x1001 → addr_err=1, mem_req never asserted, WriteReg_WB=0, no stall.
- rst low during REQ with ack withheld → mem_req and stall_req 0 immediately; after release, state IDLE, next op runs normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus sequencing, byte lanes, load extension, pipeline hold.
// Optional MEM_ALIGN_CHECK_EN: flag misaligned half/word accesses instead of masking the low address bits.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr_MEM,
  input  logic [DATA_W-1:0] rdata_2_MEM,
  input  logic              ReadMem_MEM,
  input  logic              WriteMem_MEM,
  input  logic              MemOrAlu_MEM,
  input  logic              WriteReg_MEM,
  input  logic [OPC_W-1:0]  opcode_MEM,
  input  logic [4:0]        target_MEM,
  mem_access_unit_if.master bus,
  output logic              stall_req,
  output logic [DATA_W-1:0] result_WB,
  output logic [4:0]        target_WB,
  output logic              WriteReg_WB,
  output logic              addr_err
);

  localparam logic [OPC_W-1:0] OP_LB  = OPC_W'(6'h20);
  localparam logic [OPC_W-1:0] OP_LH  = OPC_W'(6'h21);
  localparam logic [OPC_W-1:0] OP_LBU = OPC_W'(6'h24);
  localparam logic [OPC_W-1:0] OP_LHU = OPC_W'(6'h25);
  localparam logic [OPC_W-1:0] OP_SB  = OPC_W'(6'h28);
  localparam logic [OPC_W-1:0] OP_SH  = OPC_W'(6'h29);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_op;
  logic              is_write;
  logic [3:0]        store_be;
  logic [DATA_W-1:0] store_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;

  assign mem_op   = ReadMem_MEM | WriteMem_MEM;
  // Read wins when both controls are set.
  assign is_write = WriteMem_MEM & ~ReadMem_MEM;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [OPC_W-1:0] OP_LW = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OP_SW = OPC_W'(6'h2B);

  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (opcode_MEM)
      OP_LH, OP_LHU, OP_SH: misaligned = addr_MEM[0];
      OP_LW, OP_SW:         misaligned = |addr_MEM[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign addr_err = rst & (state == IDLE) & mem_op & misaligned;
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == REQ && bus.mem_ack) rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !addr_err) state_nxt = REQ;
      REQ:     if (bus.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    store_be   = 4'b1111;
    store_data = rdata_2_MEM;
    case (opcode_MEM)
      OP_SB: begin
        store_be   = 4'b0001 << addr_MEM[1:0];
        store_data = {(DATA_W/8){rdata_2_MEM[7:0]}};
      end
      OP_SH: begin
        store_be   = addr_MEM[1] ? 4'b1100 : 4'b0011;
        store_data = {(DATA_W/16){rdata_2_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus fields follow the EX/MEM inputs directly; the stall keeps them frozen until ack.
  assign bus.mem_req   = (state == REQ);
  assign bus.mem_we    = (state == REQ) & is_write;
  assign bus.mem_be    = (state == REQ) ? (is_write ? store_be : 4'b1111) : 4'b0000;
  assign bus.mem_addr  = {addr_MEM[DATA_W-1:2], 2'b00};
  assign bus.mem_wdata = store_data;

  always_comb begin
    byte_sel = rdata_q[{addr_MEM[1:0], 3'b000} +: 8];
    half_sel = rdata_q[{addr_MEM[1], 4'b0000} +: 16];
    case (opcode_MEM)
      OP_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      OP_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  // Gated by rst so the hold drops the instant reset is asserted, even with a memory op still presented.
  assign stall_req   = rst & (((state == IDLE) & mem_op & ~addr_err) | (state == REQ));
  assign result_WB   = MemOrAlu_MEM ? (addr_err ? '0 : load_data) : addr_MEM;
  assign target_WB   = target_MEM;
  assign WriteReg_WB = WriteReg_MEM & ~addr_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory model, randomized bus wait states.
module tb_mem_access_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] addr_MEM = '0, rdata_2_MEM = '0;
  logic          ReadMem_MEM = 1'b0, WriteMem_MEM = 1'b0, MemOrAlu_MEM = 1'b0, WriteReg_MEM = 1'b0;
  logic [5:0]    opcode_MEM = '0;
  logic [4:0]    target_MEM = '0;
  logic          stall_req, WriteReg_WB, addr_err;
  logic [DW-1:0] result_WB;
  logic [4:0]    target_WB;

  mem_access_unit_if #(.DATA_W(DW)) bus ();

  mem_access_unit #(.DATA_W(DW), .OPC_W(6)) dut (
    .clk(clk), .rst(rst),
    .addr_MEM(addr_MEM), .rdata_2_MEM(rdata_2_MEM),
    .ReadMem_MEM(ReadMem_MEM), .WriteMem_MEM(WriteMem_MEM),
    .MemOrAlu_MEM(MemOrAlu_MEM), .WriteReg_MEM(WriteReg_MEM),
    .opcode_MEM(opcode_MEM), .target_MEM(target_MEM),
    .bus(bus),
    .stall_req(stall_req), .result_WB(result_WB), .target_WB(target_WB),
    .WriteReg_WB(WriteReg_WB), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tgt;
    logic        wreg;
    logic        err;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic        inst_valid = 1'b0;
  logic [31:0] bus_mem [64];
  logic [7:0]  ref_mem [256];
  int          ack_wait = -1;
  bit          idle_noise = 1'b1;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;
  int          req_cycles;
  logic        tr_req[$], tr_stall[$], tr_err[$];
  int          cycles;
  logic [5:0]  ld_ops [6] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h22};
  logic [5:0]  st_ops [3] = '{6'h28, 6'h29, 6'h2B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array; accesses are naturally aligned chunks of 1/2/4 bytes.
  function automatic logic [31:0] ref_access(input logic rd, input logic wr, input logic mor,
                                             input logic [5:0] opc, input logic [31:0] addr,
                                             input logic [31:0] wdata, output logic err);
    int unsigned size;
    logic [7:0]  base;
    logic [31:0] v;
    err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((rd || wr) && ((((opc == 6'h21) || (opc == 6'h25) || (opc == 6'h29)) && addr[0]) ||
                       (((opc == 6'h23) || (opc == 6'h2B)) && (addr[1:0] != 2'b00))))
      err = 1'b1;
`endif
    if (err) return mor ? 32'h0 : addr;
    if (rd) begin
      size = (opc == 6'h20 || opc == 6'h24) ? 1 : (opc == 6'h21 || opc == 6'h25) ? 2 : 4;
      base = addr[7:0] & ~8'(size - 1);
      v = 32'h0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_mem[base + 8'(i)]) << (8 * i));
      if (opc == 6'h20 && v[7])  v = v | 32'hFFFF_FF00;
      if (opc == 6'h21 && v[15]) v = v | 32'hFFFF_0000;
      return mor ? v : addr;
    end
    if (wr) begin
      size = (opc == 6'h28) ? 1 : (opc == 6'h29) ? 2 : 4;
      base = addr[7:0] & ~8'(size - 1);
      for (int unsigned i = 0; i < size; i++) ref_mem[base + 8'(i)] = wdata[8 * i +: 8];
    end
    return addr;
  endfunction

  // Data memory slave: random or fixed ack latency, random ack/rdata noise while no request is pending.
  initial begin
    int waited;
    int tgt_wait;
    waited = 0;
    tgt_wait = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (waited == 0) begin
          tgt_wait = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
          req_cycles = 0;
        end
        req_cycles++;
        if (waited >= tgt_wait) begin
          bus.mem_ack = 1'b1;
          last_be = bus.mem_be;
          last_we = bus.mem_we;
          last_wdata = bus.mem_wdata;
          if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) bus_mem[bus.mem_addr[7:2]][8 * i +: 8] = bus.mem_wdata[8 * i +: 8];
            bus.mem_rdata = $urandom;
          end else begin
            bus.mem_rdata = bus_mem[bus.mem_addr[7:2]];
          end
          waited = 0;
        end else begin
          bus.mem_ack = 1'b0;
          waited++;
        end
      end else begin
        waited = 0;
        bus.mem_ack = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every cycle the pipeline would advance on a valid instruction, consume one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && inst_valid && stall_req === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: unexpected output result_WB=%h", result_WB);
        end else begin
          e = exp_q.pop_front();
          check("result_WB", result_WB, e.res);
          check("target_WB", 32'(target_WB), 32'(e.tgt));
          check("WriteReg_WB", 32'(WriteReg_WB), 32'(e.wreg));
          check("addr_err", 32'(addr_err), 32'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic mor, input logic wreg,
                       input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] tgt, input bit use_exp, input logic [31:0] exp_res);
    exp_t e;
    logic err;
    e.res = ref_access(rd, wr, mor, opc, addr, wdata, err);
    if (use_exp) e.res = exp_res;
    e.tgt = tgt;
    e.wreg = wreg & ~err;
    e.err = err;
    exp_q.push_back(e);
    ReadMem_MEM = rd; WriteMem_MEM = wr; MemOrAlu_MEM = mor; WriteReg_MEM = wreg;
    opcode_MEM = opc; addr_MEM = addr; rdata_2_MEM = wdata; target_MEM = tgt;
    inst_valid = 1'b1;
    tr_req.delete(); tr_stall.delete(); tr_err.delete();
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      tr_req.push_back(bus.mem_req);
      tr_stall.push_back(stall_req);
      tr_err.push_back(addr_err);
    end while (stall_req !== 1'b0 && cycles < 60);
    if (stall_req !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL timeout: stall_req still %b after %0d cycles, required 0", stall_req, cycles);
    end
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    ReadMem_MEM = 1'b0;
    WriteMem_MEM = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      bus_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = bus_mem[i][8 * b +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", 32'(bus.mem_req), 32'h0);
    check("reset mem_we", 32'(bus.mem_we), 32'h0);
    check("reset mem_be", 32'(bus.mem_be), 32'h0);
    check("reset stall_req", 32'(stall_req), 32'h0);
    check("reset addr_err", 32'(addr_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 32'h1234_5678);
    check("nonmem cycles", 32'(cycles), 32'd1);

    ack_wait = 0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 6'h2B, 32'h0000_1000, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h0000_1000);
    check("sw cycles", 32'(cycles), 32'd3);
    check("sw req trace", 32'({tr_req[0], tr_req[1], tr_req[2]}), 32'b010);
    check("sw stall trace", 32'({tr_stall[0], tr_stall[1], tr_stall[2]}), 32'b110);
    check("sw be", 32'(last_be), 32'hF);
    check("sw we", 32'(last_we), 32'h1);
    check("sw wdata", last_wdata, 32'hDEAD_BEEF);

    bus_mem[0] = 32'h8000_0000;
    for (int b = 0; b < 4; b++) ref_mem[b] = bus_mem[0][8 * b +: 8];
    issue(1'b1, 1'b0, 1'b1, 1'b1, 6'h20, 32'h0000_1003, 32'h0, 5'd4, 1'b1, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 6'h24, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 32'h0000_0080);

    ack_wait = 3;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 6'h29, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0);
    check("sh be", 32'(last_be), 32'hC);
    check("sh wdata", last_wdata, 32'hABCD_ABCD);
    check("sh req cycles", 32'(req_cycles), 32'd4);
    check("sh cycles", 32'(cycles), 32'd6);
    check("sh stall trace", 32'({tr_stall[0], tr_stall[3], tr_stall[4], tr_stall[5]}), 32'b1110);

    ack_wait = 0;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 6'h23, 32'h0000_1000, 32'h0, 5'd6, 1'b1, 32'hABCD_0000);
    w = 32'(cycles);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 6'h21, 32'h0000_2002, 32'h0, 5'd7, 1'b1, 32'hFFFF_ABCD);
    check("lw+lh cycles", w + 32'(cycles), 32'd6);

`ifdef MEM_ALIGN_CHECK_EN
    issue(1'b1, 1'b0, 1'b1, 1'b1, 6'h23, 32'h0000_1001, 32'h0, 5'd8, 1'b1, 32'h0);
    check("align cycles", 32'(cycles), 32'd1);
    check("align req", 32'(tr_req[0]), 32'h0);
    check("align stall", 32'(tr_stall[0]), 32'h0);
    check("align err", 32'(tr_err[0]), 32'h1);
`endif

    ack_wait = 1000;
    idle_noise = 1'b0;
    ReadMem_MEM = 1'b1; MemOrAlu_MEM = 1'b1; opcode_MEM = 6'h23; addr_MEM = 32'h0000_1004;
    @(negedge clk);
    @(negedge clk);
    check("abandon req before reset", 32'(bus.mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abandon req in reset", 32'(bus.mem_req), 32'h0);
    check("abandon stall in reset", 32'(stall_req), 32'h0);
    ReadMem_MEM = 1'b0; MemOrAlu_MEM = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("after reset req", 32'(bus.mem_req), 32'h0);
    check("after reset stall", 32'(stall_req), 32'h0);
    ack_wait = -1;
    idle_noise = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind < 2)
        issue(1'b0, 1'b0, 1'b0, 1'($urandom), 6'($urandom), $urandom, $urandom, 5'($urandom), 1'b0, 32'h0);
      else if (kind < 6)
        issue(1'b1, 1'b0, 1'b1, 1'($urandom), ld_ops[$urandom_range(0, 5)], $urandom, $urandom,
              5'($urandom), 1'b0, 32'h0);
      else if (kind < 9)
        issue(1'b0, 1'b1, 1'b0, 1'($urandom), st_ops[$urandom_range(0, 2)], $urandom, $urandom,
              5'($urandom), 1'b0, 32'h0);
      else
        issue(1'b1, 1'b1, 1'b1, 1'($urandom), ld_ops[$urandom_range(0, 5)], $urandom, $urandom,
              5'($urandom), 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end
    for (int i = 0; i < 64; i++) begin
      for (int b = 0; b < 4; b++) w[8 * b +: 8] = ref_mem[4 * i + b];
      check($sformatf("memory word %0d", i), bus_mem[i], w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
